// File: rtl/bram_arbiter.sv
// Round-robin arbiter for two req/ack requesters sharing one BRAM port, with a
// background fill engine that writes a constant byte using otherwise idle cycles.
module bram_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [7:0]  wdata0,
  input  logic [7:0]  wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [7:0]  rdata0,
  output logic [7:0]  rdata1,
  input  logic        fill_start,
  input  logic [15:0] fill_base,
  input  logic [16:0] fill_count,
  input  logic [7:0]  fill_value,
  output logic        fill_busy,
  output logic        fill_done,
  output logic        bram_we,
  output logic [15:0] bram_addr,
  output logic [7:0]  bram_di,
  input  logic [7:0]  bram_do
);

  typedef enum logic {FILL_IDLE, FILL_RUN} fill_state_e;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  // Arbiter and pipeline state
  logic        pend0_q, pend0_d;
  logic        pend1_q, pend1_d;
  logic        last_q, last_d;
  tag_t        iss_q, iss_d;
  tag_t        ackt_q, ackt_d;
  logic        bram_we_q, bram_we_d;
  logic [15:0] bram_addr_q, bram_addr_d;
  logic [7:0]  bram_di_q, bram_di_d;

  // Fill engine state
  fill_state_e state_q, state_d;
  logic [15:0] fill_addr_q, fill_addr_d;
  logic [16:0] fill_rem_q, fill_rem_d;
  logic        fill_done_q, fill_done_d;
  logic        fill_slot;

  logic elig0, elig1, grant_any, grant_id;

  assign elig0     = req0 && !pend0_q;
  assign elig1     = req1 && !pend1_q;
  assign grant_any = elig0 || elig1;
  // On a tie the port not granted most recently wins.
  assign grant_id  = (elig0 && elig1) ? ~last_q : elig1;

  assign ack0   = ackt_q.valid && !ackt_q.id;
  assign ack1   = ackt_q.valid &&  ackt_q.id;
  assign rdata0 = bram_do;
  assign rdata1 = bram_do;

  assign bram_we   = bram_we_q;
  assign bram_addr = bram_addr_q;
  assign bram_di   = bram_di_q;
  assign fill_done = fill_done_q;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    pend0_d     = pend0_q;
    pend1_d     = pend1_q;
    last_d      = last_q;
    bram_we_d   = 1'b0;
    bram_addr_d = bram_addr_q;
    bram_di_d   = bram_di_q;
    iss_d       = '{valid: grant_any, id: grant_id};
    ackt_d      = iss_q;

    if (ack0) pend0_d = 1'b0;
    if (ack1) pend1_d = 1'b0;

    if (grant_any) begin
      last_d = grant_id;
      if (grant_id) begin
        pend1_d     = 1'b1;
        bram_we_d   = we1;
        bram_addr_d = addr1;
        bram_di_d   = wdata1;
      end else begin
        pend0_d     = 1'b1;
        bram_we_d   = we0;
        bram_addr_d = addr0;
        bram_di_d   = wdata0;
      end
    end else if (fill_slot) begin
      bram_we_d   = 1'b1;
      bram_addr_d = fill_addr_q;
      bram_di_d   = fill_value;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend0_q     <= 1'b0;
      pend1_q     <= 1'b0;
      last_q      <= 1'b1;
      iss_q       <= '0;
      ackt_q      <= '0;
      bram_we_q   <= 1'b0;
      bram_addr_q <= '0;
      bram_di_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      pend0_q     <= pend0_d;
      pend1_q     <= pend1_d;
      last_q      <= last_d;
      iss_q       <= iss_d;
      ackt_q      <= ackt_d;
      bram_we_q   <= bram_we_d;
      bram_addr_q <= bram_addr_d;
      bram_di_q   <= bram_di_d;
    end
  end

  // Fill engine: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL_IDLE;
      fill_addr_q <= '0;
      fill_rem_q  <= '0;
      fill_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_addr_q <= fill_addr_d;
      fill_rem_q  <= fill_rem_d;
      fill_done_q <= fill_done_d;
    end
  end

  // Fill engine: next state
  always_comb begin
    state_d     = state_q;
    fill_addr_d = fill_addr_q;
    fill_rem_d  = fill_rem_q;
    fill_done_d = 1'b0;
    case (state_q)
      FILL_IDLE: begin
        if (fill_start) begin
          fill_addr_d = fill_base;
          fill_rem_d  = fill_count;
          if (fill_count == 17'd0) fill_done_d = 1'b1;
          else                     state_d     = FILL_RUN;
        end
      end
      FILL_RUN: begin
        if (fill_slot) begin
          fill_addr_d = fill_addr_q + 16'd1;
          fill_rem_d  = fill_rem_q - 17'd1;
          if (fill_rem_q == 17'd1) begin
            state_d     = FILL_IDLE;
            fill_done_d = 1'b1;
          end
        end
      end
    endcase
  end

  // Fill engine: outputs; requester grants always take the slot first.
  always_comb begin
    fill_busy = (state_q == FILL_RUN);
    fill_slot = (state_q == FILL_RUN) && !grant_any;
  end

endmodule

// File: tb/tb_bram_arbiter.sv
// Scoreboard bench for bram_arbiter: stimulus pushes expected acks, BRAM writes and
// fill_done pulses into queues; a negedge monitor pops and compares them.
module tb_bram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [15:0] addr0, addr1;
  logic [7:0]  wdata0, wdata1;
  logic        ack0, ack1;
  logic [7:0]  rdata0, rdata1;
  logic        fill_start;
  logic [15:0] fill_base;
  logic [16:0] fill_count;
  logic [7:0]  fill_value;
  logic        fill_busy, fill_done;
  logic        bram_we;
  logic [15:0] bram_addr;
  logic [7:0]  bram_di;
  logic [7:0]  bram_do = 8'h5C;

  logic [7:0]  mem [0:65535];
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic        ignore_writes = 1'b0;

  typedef struct {
    logic       rd;
    logic [7:0] data;
    int         cyc;
  } acc_t;

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  data;
    int          cyc;
  } wr_t;

  acc_t q0[$];
  acc_t q1[$];
  wr_t  wq[$];
  int   dq[$];

  bram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .fill_start(fill_start), .fill_base(fill_base), .fill_count(fill_count),
    .fill_value(fill_value), .fill_busy(fill_busy), .fill_done(fill_done),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_di(bram_di), .bram_do(bram_do)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM model: registered read, output held during writes.
  always @(posedge clk) begin
    if (bram_we) mem[bram_addr] = bram_di;
    else         bram_do <= mem[bram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic exp_write(input logic [15:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.cyc  = c;
    wq.push_back(w);
  endtask

  // Issue one access on port p and hold it until acked; lat = cycles from now to ack.
  task automatic access(input int p, input logic w, input logic [15:0] a,
                        input logic [7:0] d, input logic [7:0] exp_rd, input int lat);
    acc_t e;
    logic seen;
    e.rd   = !w;
    e.data = exp_rd;
    e.cyc  = cyc + lat;
    if (p == 0) begin
      q0.push_back(e);
      req0 = 1'b1; we0 = w; addr0 = a; wdata0 = d;
    end else begin
      q1.push_back(e);
      req1 = 1'b1; we1 = w; addr1 = a; wdata1 = d;
    end
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      seen = (p == 0) ? ack0 : ack1;
    end
    if (!seen) check($sformatf("ack%0d_timeout", p), {31'b0, seen}, 32'd1);
    if (p == 0) req0 = 1'b0;
    else        req1 = 1'b0;
  endtask

  always @(negedge clk) begin : monitor
    acc_t e;
    wr_t  w;
    int   dc;
    if (ack0) begin
      if (q0.size() == 0) check("ack0_spurious", {31'b0, ack0}, 32'd0);
      else begin
        e = q0.pop_front();
        check("ack0_cycle", cyc, e.cyc);
        if (e.rd) check("rdata0", {24'b0, rdata0}, {24'b0, e.data});
      end
    end
    if (ack1) begin
      if (q1.size() == 0) check("ack1_spurious", {31'b0, ack1}, 32'd0);
      else begin
        e = q1.pop_front();
        check("ack1_cycle", cyc, e.cyc);
        if (e.rd) check("rdata1", {24'b0, rdata1}, {24'b0, e.data});
      end
    end
    if (bram_we && !ignore_writes) begin
      if (wq.size() == 0) check("write_spurious", {31'b0, bram_we}, 32'd0);
      else begin
        w = wq.pop_front();
        check("write_addr", {16'b0, bram_addr}, {16'b0, w.addr});
        check("write_data", {24'b0, bram_di}, {24'b0, w.data});
        check("write_cycle", cyc, w.cyc);
      end
    end
    if (fill_done) begin
      check("busy_at_done", {31'b0, fill_busy}, 32'd0);
      if (dq.size() == 0) check("done_spurious", {31'b0, fill_done}, 32'd0);
      else begin
        dc = dq.pop_front();
        check("done_cycle", cyc, dc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    fill_start = 1'b0; fill_base = '0; fill_count = '0; fill_value = '0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'hA5;
    mem[16'h0100] = 8'h11;
    mem[16'h0200] = 8'h22;

    #1;
    check("rst_ack0", {31'b0, ack0}, 32'd0);
    check("rst_ack1", {31'b0, ack1}, 32'd0);
    check("rst_fill_busy", {31'b0, fill_busy}, 32'd0);
    check("rst_fill_done", {31'b0, fill_done}, 32'd0);
    check("rst_bram_we", {31'b0, bram_we}, 32'd0);
    check("rst_bram_addr", {16'b0, bram_addr}, 32'd0);
    check("rst_bram_di", {24'b0, bram_di}, 32'd0);
    check("rst_rdata0_follows", {24'b0, rdata0}, 32'h5C);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // First contest after reset: port 0, then port 1 on the next edge.
    fork
      access(0, 1'b0, 16'h0100, 8'h00, 8'h11, 2);
      access(1, 1'b0, 16'h0200, 8'h00, 8'h22, 3);
    join
    repeat (2) @(negedge clk);

    // Single read on port 0.
    access(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 2);
    repeat (2) @(negedge clk);

    // Port 0 was granted last, so port 1 wins this contest.
    fork
      access(0, 1'b0, 16'h1234, 8'h00, 8'hA5, 3);
      access(1, 1'b0, 16'h0100, 8'h00, 8'h11, 2);
    join
    repeat (2) @(negedge clk);

    // Port 1 writes, port 0 reads the same address one cycle later.
    exp_write(16'h0010, 8'h5A, cyc + 1);
    fork
      access(1, 1'b1, 16'h0010, 8'h5A, 8'h00, 2);
      begin
        @(negedge clk);
        access(0, 1'b0, 16'h0010, 8'h00, 8'h5A, 2);
      end
    join
    repeat (2) @(negedge clk);

    // Fill across the top of the address space.
    fill_base = 16'hFFFE; fill_count = 17'd4; fill_value = 8'h77; fill_start = 1'b1;
    exp_write(16'hFFFE, 8'h77, cyc + 2);
    exp_write(16'hFFFF, 8'h77, cyc + 3);
    exp_write(16'h0000, 8'h77, cyc + 4);
    exp_write(16'h0001, 8'h77, cyc + 5);
    dq.push_back(cyc + 5);
    @(negedge clk);
    fill_start = 1'b0;
    check("fill_busy_wrap", {31'b0, fill_busy}, 32'd1);
    repeat (5) @(negedge clk);
    check("fill_idle_wrap", {31'b0, fill_busy}, 32'd0);

    // Fill of 8 bytes with a port 0 read stealing one slot.
    fill_base = 16'h2000; fill_count = 17'd8; fill_value = 8'h3C; fill_start = 1'b1;
    exp_write(16'h2000, 8'h3C, cyc + 2);
    for (int i = 1; i < 8; i++) exp_write(16'h2000 + 16'(i), 8'h3C, cyc + 3 + i);
    dq.push_back(cyc + 10);
    fork
      begin
        @(negedge clk);
        fill_start = 1'b0;
      end
      begin
        repeat (2) @(negedge clk);
        access(0, 1'b0, 16'h0100, 8'h00, 8'h11, 2);
      end
    join
    repeat (8) @(negedge clk);
    check("fill_idle_preempt", {31'b0, fill_busy}, 32'd0);

    // Zero-length fill: done pulse only, no writes.
    fill_count = 17'd0; fill_start = 1'b1;
    dq.push_back(cyc + 1);
    @(negedge clk);
    fill_start = 1'b0;
    check("fill_zero_busy", {31'b0, fill_busy}, 32'd0);
    repeat (3) @(negedge clk);

    // Reset during a fill and with a port 1 read in flight.
    ignore_writes = 1'b1;
    fill_base = 16'h3000; fill_count = 17'd16; fill_value = 8'h99; fill_start = 1'b1;
    @(negedge clk);
    fill_start = 1'b0;
    begin
      acc_t e;
      e.rd = 1'b1; e.data = 8'h11; e.cyc = cyc + 2;
      q0.push_back(e);
    end
    req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0100;
    @(negedge clk);
    req1 = 1'b1; we1 = 1'b0; addr1 = 16'h1234;
    @(negedge clk);
    req0 = 1'b0;
    #2;
    rst_n = 1'b0;
    req1 = 1'b0;
    #1;
    check("midrst_ack0", {31'b0, ack0}, 32'd0);
    check("midrst_ack1", {31'b0, ack1}, 32'd0);
    check("midrst_fill_busy", {31'b0, fill_busy}, 32'd0);
    check("midrst_fill_done", {31'b0, fill_done}, 32'd0);
    check("midrst_bram_we", {31'b0, bram_we}, 32'd0);
    check("midrst_bram_addr", {16'b0, bram_addr}, 32'd0);
    check("midrst_bram_di", {24'b0, bram_di}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    ignore_writes = 1'b0;
    repeat (20) @(negedge clk);

    // Recovery access after reset.
    access(0, 1'b0, 16'h0010, 8'h00, 8'h5A, 2);
    repeat (3) @(negedge clk);

    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);
    check("writes_drained", wq.size(), 32'd0);
    check("dones_drained", dq.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
